// File: rtl/avalon_mm_pkg.sv
// Shared types and elaboration helpers for the multi-channel Avalon-MM master.
package avalon_mm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } state_t;

  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    for (longint unsigned p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  function automatic int be_width(input int w);
    return w / 8;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last grant; force_en pins the grant
// to force_idx when that channel is requesting (lock chaining).
module rr_arbiter
  import avalon_mm_pkg::*;
#(
  parameter int NCH = 2,
  localparam int IDX_W = idx_width(NCH)
) (
  input  logic [NCH-1:0]   req,
  input  logic [IDX_W-1:0] last_grant,
  input  logic             force_en,
  input  logic [IDX_W-1:0] force_idx,
  output logic [NCH-1:0]   grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  always_comb begin
    int unsigned c;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    c           = 0;
    if (force_en && req[force_idx]) begin
      grant[force_idx] = 1'b1;
      grant_idx        = force_idx;
      grant_valid      = 1'b1;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        c = (32'(last_grant) + 32'd1 + i) % NCH;
        if (!grant_valid && req[IDX_W'(c)]) begin
          grant[IDX_W'(c)] = 1'b1;
          grant_idx        = IDX_W'(c);
          grant_valid      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/avalon_mm_multi_master.sv
// Avalon-MM master shared by NCH client ports: round-robin grant, lock chaining,
// byte enables and a saturating waitrequest timeout that aborts with err.
module avalon_mm_multi_master
  import avalon_mm_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 32,
  parameter int NCH     = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NCH-1:0]             req,
  input  logic [NCH-1:0]             rnw,
  input  logic [NCH-1:0]             lock_req,
  input  logic [NCH*ADDR_W-1:0]      addr,
  input  logic [NCH*WIDTH-1:0]       wdata,
  input  logic [NCH*(WIDTH/8)-1:0]   be,
  output logic [NCH-1:0]             done,
  output logic [NCH-1:0]             err,
  output logic [WIDTH-1:0]           rdata,
  output logic [ADDR_W-1:0]          ADDRESS,
  output logic                       BEGINTRANSFER,
  output logic                       READ,
  output logic                       WRITE,
  output logic [WIDTH-1:0]           WRITEDATA,
  output logic [(WIDTH/8)-1:0]       BYTEENABLE,
  output logic                       LOCK,
  input  logic [WIDTH-1:0]           READDATA,
  input  logic                       WAITREQUEST
);

  localparam int BE_W  = be_width(WIDTH);
  localparam int IDX_W = idx_width(NCH);
  localparam int CNT_W = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic                rnw_q, rnw_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W:0]      cnt_inc;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]    wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic                bt_q, bt_d;
  logic                lock_q, lock_d;
  logic [NCH-1:0]      done_q, done_d;
  logic [NCH-1:0]      err_q, err_d;
  logic [WIDTH-1:0]    rdata_q, rdata_d;

  logic                force_en;
  logic [NCH-1:0]      grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_valid;

  // LOCK can only be high in IDLE when the previous transfer was locked.
  assign force_en = (state_q == IDLE) && lock_q;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req         (req),
    .last_grant  (last_q),
    .force_en    (force_en),
    .force_idx   (last_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    rnw_d   = rnw_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    read_d  = read_q;
    write_d = write_q;
    bt_d    = 1'b0;
    lock_d  = lock_q;
    done_d  = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);

    unique case (state_q)
      IDLE: begin
        lock_d = 1'b0;
        if (grant_valid) begin
          state_d = BUS;
          gidx_d  = grant_idx;
          bt_d    = 1'b1;
          cnt_d   = '0;
          for (int unsigned i = 0; i < NCH; i++) begin
            if (grant[i]) begin
              rnw_d   = rnw[i];
              addr_d  = addr[i*ADDR_W +: ADDR_W];
              wdata_d = wdata[i*WIDTH +: WIDTH];
              be_d    = be[i*BE_W +: BE_W];
              lock_d  = lock_req[i];
            end
          end
          read_d  = rnw_d;
          write_d = !rnw_d;
        end
      end
      BUS: begin
        if (!WAITREQUEST) begin
          if (rnw_q) rdata_d = READDATA;
          read_d          = 1'b0;
          write_d         = 1'b0;
          done_d[gidx_q]  = 1'b1;
          state_d         = DONE;
        end else if (TIMEOUT != 0 && cnt_inc == (CNT_W + 1)'(TIMEOUT)) begin
          read_d          = 1'b0;
          write_d         = 1'b0;
          done_d[gidx_q]  = 1'b1;
          err_d[gidx_q]   = 1'b1;
          state_d         = DONE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      DONE: begin
        last_d  = gidx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      last_q  <= IDX_W'(NCH - 1);
      rnw_q   <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      bt_q    <= 1'b0;
      lock_q  <= 1'b0;
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      rnw_q   <= rnw_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      read_q  <= read_d;
      write_q <= write_d;
      bt_q    <= bt_d;
      lock_q  <= lock_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign done          = done_q;
  assign err           = err_q;
  assign rdata         = rdata_q;
  assign ADDRESS       = addr_q;
  assign BEGINTRANSFER = bt_q;
  assign READ          = read_q;
  assign WRITE         = write_q;
  assign WRITEDATA     = wdata_q;
  assign BYTEENABLE    = be_q;
  assign LOCK          = lock_q;

endmodule

// File: tb/tb_avalon_mm_multi_master.sv
// Directed bench for avalon_mm_multi_master: per-cycle vector table plus
// hand-written wait-state, timeout and reset sequences.
module tb_avalon_mm_multi_master;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  req, rnw, lock_req;
  logic [63:0] addr, wdata;
  logic [7:0]  be;
  logic [1:0]  done, err;
  logic [31:0] rdata, ADDRESS, WRITEDATA, READDATA;
  logic        BEGINTRANSFER, READ, WRITE, LOCK, WAITREQUEST;
  logic [3:0]  BYTEENABLE;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  assign addr  = {32'h0000_0200, 32'h0000_0100};
  assign wdata = {32'h1234_5678, 32'hA5A5_0000};
  assign be    = {4'b0011, 4'b1111};

  avalon_mm_multi_master #(
    .WIDTH   (32),
    .ADDR_W  (32),
    .NCH     (2),
    .TIMEOUT (8)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .req           (req),
    .rnw           (rnw),
    .lock_req      (lock_req),
    .addr          (addr),
    .wdata         (wdata),
    .be            (be),
    .done          (done),
    .err           (err),
    .rdata         (rdata),
    .ADDRESS       (ADDRESS),
    .BEGINTRANSFER (BEGINTRANSFER),
    .READ          (READ),
    .WRITE         (WRITE),
    .WRITEDATA     (WRITEDATA),
    .BYTEENABLE    (BYTEENABLE),
    .LOCK          (LOCK),
    .READDATA      (READDATA),
    .WAITREQUEST   (WAITREQUEST)
  );

  typedef struct {
    logic [1:0]  req, rnw, lk;
    logic        wr;
    logic [31:0] rd;
    logic [1:0]  e_done;
    logic        e_rd, e_wr, e_bt, e_lock;
    logic [31:0] e_addr, e_rdata;
  } vec_t;

  vec_t tbl[24];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int wcnt, btc, d0, d1, ec, rc, dcyc, errwith, e1;

    // Rows: inputs during a cycle; expectations visible just after the edge ending it.
    //          req    rnw    lk     wr    rd              done   rd    wr    bt    lock  addr         rdata
    tbl[0]  = '{2'b11, 2'b11, 2'b00, 1'b0, 32'h0,        2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0};
    tbl[1]  = '{2'b11, 2'b11, 2'b00, 1'b0, 32'h11111111, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h11111111};
    tbl[2]  = '{2'b11, 2'b11, 2'b00, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h11111111};
    tbl[3]  = '{2'b11, 2'b11, 2'b00, 1'b0, 32'h0,        2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h11111111};
    tbl[4]  = '{2'b11, 2'b11, 2'b00, 1'b0, 32'h22222222, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 32'h22222222};
    tbl[5]  = '{2'b11, 2'b11, 2'b00, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 32'h22222222};
    tbl[6]  = '{2'b11, 2'b11, 2'b00, 1'b0, 32'h0,        2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h22222222};
    tbl[7]  = '{2'b11, 2'b11, 2'b00, 1'b0, 32'h33333333, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h33333333};
    tbl[8]  = '{2'b11, 2'b11, 2'b00, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h33333333};
    tbl[9]  = '{2'b11, 2'b11, 2'b00, 1'b0, 32'h0,        2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h33333333};
    tbl[10] = '{2'b11, 2'b11, 2'b00, 1'b0, 32'h44444444, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 32'h44444444};
    tbl[11] = '{2'b00, 2'b11, 2'b00, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 32'h44444444};
    tbl[12] = '{2'b11, 2'b10, 2'b01, 1'b0, 32'h0,        2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 32'h44444444};
    tbl[13] = '{2'b11, 2'b10, 2'b01, 1'b0, 32'h0,        2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h44444444};
    tbl[14] = '{2'b11, 2'b10, 2'b00, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h44444444};
    tbl[15] = '{2'b11, 2'b10, 2'b00, 1'b0, 32'h0,        2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h44444444};
    tbl[16] = '{2'b11, 2'b10, 2'b00, 1'b0, 32'h0,        2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h44444444};
    tbl[17] = '{2'b11, 2'b10, 2'b00, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h44444444};
    tbl[18] = '{2'b11, 2'b10, 2'b00, 1'b0, 32'h0,        2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h44444444};
    tbl[19] = '{2'b11, 2'b10, 2'b00, 1'b0, 32'h55555555, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 32'h55555555};
    tbl[20] = '{2'b00, 2'b10, 2'b00, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 32'h55555555};
    tbl[21] = '{2'b01, 2'b01, 2'b00, 1'b0, 32'h0,        2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h55555555};
    tbl[22] = '{2'b01, 2'b01, 2'b00, 1'b0, 32'hDEADBEEF, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF};
    tbl[23] = '{2'b00, 2'b01, 2'b00, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF};

    RST = 1'b1; req = '0; rnw = '0; lock_req = '0; WAITREQUEST = 1'b0; READDATA = '0;
    tick();
    tick();
    check("reset_outputs",
          {READ, WRITE, BEGINTRANSFER, LOCK, done, err, ADDRESS, WRITEDATA, BYTEENABLE, rdata}, '0);
    RST = 1'b0;

    // Round-robin from reset, lock chaining, single read.
    for (int i = 0; i < 24; i++) begin
      req = tbl[i].req; rnw = tbl[i].rnw; lock_req = tbl[i].lk;
      WAITREQUEST = tbl[i].wr; READDATA = tbl[i].rd;
      tick();
      check($sformatf("row%0d", i),
            {READ, WRITE, BEGINTRANSFER, LOCK, done, err, ADDRESS, rdata},
            {tbl[i].e_rd, tbl[i].e_wr, tbl[i].e_bt, tbl[i].e_lock, tbl[i].e_done, 2'b00,
             tbl[i].e_addr, tbl[i].e_rdata});
    end

    // ch1 write with three wait states; req dropped right after the grant.
    req = 2'b10; rnw = 2'b00; lock_req = 2'b00; WAITREQUEST = 1'b1;
    tick();
    check("t2_cmd", {WRITE, READ, BEGINTRANSFER, ADDRESS, WRITEDATA, BYTEENABLE},
          {1'b1, 1'b0, 1'b1, 32'h200, 32'h12345678, 4'b0011});
    wcnt = int'(WRITE); btc = int'(BEGINTRANSFER); d0 = 0; d1 = 0; ec = 0;
    req = 2'b00;
    for (int k = 0; k < 10; k++) begin
      WAITREQUEST = (k < 3);
      tick();
      wcnt += int'(WRITE); btc += int'(BEGINTRANSFER);
      d0 += int'(done[0]); d1 += int'(done[1]); ec += int'(|err);
    end
    WAITREQUEST = 1'b0;
    check("t2_write_cycles", wcnt, 4);
    check("t2_begintransfer_cycles", btc, 1);
    check("t2_done1_pulses", d1, 1);
    check("t2_no_done0_no_err", {d0, ec}, 0);
    check("t2_rdata_kept", rdata, 32'hDEADBEEF);

    // ch0 read with WAITREQUEST stuck high: abort after 8 wait cycles.
    req = 2'b01; rnw = 2'b01; WAITREQUEST = 1'b1; READDATA = 32'hBAD0BAD0;
    tick();
    rc = int'(READ); dcyc = -1; errwith = 0; e1 = 0; d0 = 0;
    req = 2'b00;
    for (int k = 0; k < 20; k++) begin
      tick();
      rc += int'(READ);
      e1 += int'(err[1]);
      if (done[0]) begin
        d0++;
        dcyc = k;
        errwith = int'(err[0]);
      end
    end
    WAITREQUEST = 1'b0;
    check("t5_read_cycles", rc, 8);
    check("t5_done_cycle", dcyc, 7);
    check("t5_err_with_done", {d0, errwith}, {32'd1, 32'd1});
    check("t5_no_err_ch1", e1, 0);
    check("t5_rdata_unchanged", rdata, 32'hDEADBEEF);

    // Reset while stalled in BUS, then a clean transfer.
    req = 2'b10; rnw = 2'b10; WAITREQUEST = 1'b1;
    tick();
    tick();
    check("t6_in_bus", {READ, done}, {1'b1, 2'b00});
    RST = 1'b1;
    tick();
    check("t6_reset_outputs",
          {READ, WRITE, BEGINTRANSFER, LOCK, done, err, ADDRESS, WRITEDATA, BYTEENABLE, rdata}, '0);
    RST = 1'b0; req = 2'b00; WAITREQUEST = 1'b0;
    tick();
    check("t6_quiet_after_reset", {READ, WRITE, done, err}, '0);
    req = 2'b01; rnw = 2'b01; READDATA = 32'hCAFEF00D;
    tick();
    check("t6_new_cmd", {READ, BEGINTRANSFER, ADDRESS}, {1'b1, 1'b1, 32'h100});
    tick();
    check("t6_new_done", {done, err, READ, rdata}, {2'b01, 2'b00, 1'b0, 32'hCAFEF00D});
    req = 2'b00;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
